// File: rtl/disp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scheduler_pkg
//  Description : Shared types and constants for the display channel scheduler.
//                Optional feature macro used by the scheduler: DISP_ALARM_BLINK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_scheduler_pkg;

  localparam int NUM_CHAN = 4;
  localparam int CHAN_W   = 2;
  localparam int DWELL_W  = 28;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW    = 2'd1,
    ST_ADVANCE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/disp_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : disp_rr_pick
//  Description : Combinational round-robin first-set search over the channel
//                request vector, beginning at start_i and wrapping modulo
//                NUM_CHAN.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_rr_pick
  import disp_scheduler_pkg::*;
(
  input  logic [NUM_CHAN-1:0] req_i,
  input  logic [CHAN_W-1:0]   start_i,
  output logic [CHAN_W-1:0]   idx_o,
  output logic                found_o
);

  logic [CHAN_W-1:0] w_cand;

  // Walk the channels from start_i upward; the first set request wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      w_cand = start_i + CHAN_W'(k);
      if (!found_o && req_i[w_cand]) begin
        found_o = 1'b1;
        idx_o   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scheduler
//  Description : Cycles a 4-digit hex display through four captured channel
//                values, dwelling DWELL_CYCLES on each, with pause and manual
//                advance. Define DISP_ALARM_BLINK_EN to blink the display
//                while a channel flagged with an alarm is shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scheduler
  import disp_scheduler_pkg::*;
#(
  parameter int DWELL_CYCLES = 200000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_valid,
  input  logic [63:0] src_data,
  input  logic [3:0]  src_alarm,
  input  logic        pause,
  input  logic        next,
  output logic [15:0] display_value,
  output logic [1:0]  cur_chan,
  output logic        disp_blank,
  output logic        chan_start
);

  localparam logic [DWELL_W-1:0] c_DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CHAN_W-1:0]    cur_chan_q, cur_chan_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 chan_start_q;
  logic [15:0]          data_q [NUM_CHAN];
  logic [NUM_CHAN-1:0]  populated_q;

  logic [CHAN_W-1:0]    w_rr_start;
  logic [CHAN_W-1:0]    w_pick_idx;
  logic                 w_pick_found;
  logic                 w_alarm_blank;

  // Capture channel values; runs in every state so a capture coinciding with
  // an advance is already visible to the search in the ADVANCE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        data_q[i] <= '0;
      end
      populated_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (src_valid[i]) begin
          data_q[i]      <= src_data[16*i +: 16];
          populated_q[i] <= 1'b1;
        end
      end
    end
  end

  assign w_rr_start = cur_chan_q + CHAN_W'(1);

  disp_rr_pick u_rr_pick (
    .req_i   (populated_q),
    .start_i (w_rr_start),
    .idx_o   (w_pick_idx),
    .found_o (w_pick_found)
  );

  // State, channel index, dwell counter and the registered start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_chan_q   <= '0;
      dwell_q      <= '0;
      chan_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_chan_q   <= cur_chan_d;
      dwell_q      <= dwell_d;
      chan_start_q <= (state_d == ST_ADVANCE);
    end
  end

  // Next-state logic: a manual advance overrides pause and the dwell count.
  always_comb begin
    state_d    = state_q;
    cur_chan_d = cur_chan_q;
    dwell_d    = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (|populated_q) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        dwell_d = '0;
        if (w_pick_found) begin
          cur_chan_d = w_pick_idx;
          state_d    = ST_SHOW;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (next) begin
          state_d = ST_ADVANCE;
        end else if (!pause) begin
          if (dwell_q == c_DWELL_LAST) begin
            state_d = ST_ADVANCE;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DISP_ALARM_BLINK_EN
  localparam logic [DWELL_W-1:0] c_BLINK_LAST = DWELL_W'(BLINK_CYCLES - 1);

  logic [NUM_CHAN-1:0] alarm_q;
  logic [DWELL_W-1:0]  blink_cnt_q;
  logic                blink_phase_q;

  // Alarm flags travel with the channel capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (src_valid[i]) begin
          alarm_q[i] <= src_alarm[i];
        end
      end
    end
  end

  // Blink timebase restarts outside SHOW so each display period opens unblanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (state_q != ST_SHOW) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == c_BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + DWELL_W'(1);
    end
  end

  assign w_alarm_blank = (state_q == ST_SHOW) && alarm_q[cur_chan_q] && blink_phase_q;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = (^src_alarm) ^ (BLINK_CYCLES != 0);
  assign w_alarm_blank  = 1'b0;
`endif

  // Display outputs: blanked and zero while nothing has been captured.
  always_comb begin
    display_value = '0;
    disp_blank    = 1'b1;
    if (state_q != ST_IDLE) begin
      display_value = data_q[cur_chan_q];
      disp_blank    = w_alarm_blank;
    end
  end

  assign cur_chan   = cur_chan_q;
  assign chan_start = chan_start_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_scheduler
//  Description : Self-checking bench for disp_scheduler; expected channel
//                switches are queued when channels are written and compared
//                whenever the scheduler pulses chan_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scheduler;

  localparam int c_DWELL = 10;
  localparam int c_BLINK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [63:0] src_data = '0;
  logic [3:0]  src_alarm = '0;
  logic        pause = 1'b0;
  logic        next = 1'b0;
  logic [15:0] display_value;
  logic [1:0]  cur_chan;
  logic        disp_blank;
  logic        chan_start;

  disp_scheduler #(
    .DWELL_CYCLES (c_DWELL),
    .BLINK_CYCLES (c_BLINK)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_alarm     (src_alarm),
    .pause         (pause),
    .next          (next),
    .display_value (display_value),
    .cur_chan      (cur_chan),
    .disp_blank    (disp_blank),
    .chan_start    (chan_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int chan;
    int value;
    int gap;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  bit          mon_en = 1'b0;
  bit          pending = 1'b0;
  logic [15:0] m_data [4];
  logic [3:0]  m_pop = '0;
  int          m_cur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [3:0] pop, input int start);
    for (int k = 0; k < 4; k++) begin
      if (pop[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Queue the next n channel switches the scheduler should make.
  task automatic predict(input int n, input int first_gap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      m_cur   = m_pick(m_pop, (m_cur + 1) % 4);
      e.chan  = m_cur;
      e.value = int'(m_data[m_cur]);
      e.gap   = (i == 0) ? first_gap : c_DWELL + 1;
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: gap measured at chan_start, channel/value one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        check_eq("sb_cur_chan", 32'(cur_chan), cur_exp.chan);
        check_eq("sb_display", 32'(display_value), cur_exp.value);
        check_eq("sb_blank", 32'(disp_blank), 0);
      end
      if (chan_start && mon_en) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_start", 32'(chan_start), 0);
        end else begin
          cur_exp = sb.pop_front();
          if (cur_exp.gap != 0) check_eq("sb_gap", cyc - last_cyc, cur_exp.gap);
          pending = 1'b1;
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic reset_dut(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_rst_display"}, 32'(display_value), 0);
    check_eq({tag, "_rst_chan"}, 32'(cur_chan), 0);
    check_eq({tag, "_rst_blank"}, 32'(disp_blank), 1);
    check_eq({tag, "_rst_start"}, 32'(chan_start), 0);
    sb.delete();
    m_pop = '0;
    m_cur = 0;
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic write_chans(input logic [3:0] v, input logic [63:0] d, input logic [3:0] a);
    @(negedge clk);
    src_valid = v;
    src_data  = d;
    src_alarm = a;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        m_data[i] = d[16*i +: 16];
        m_pop[i]  = 1'b1;
      end
    end
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!chan_start && i < budget);
    if (!chan_start) check_eq({tag, "_start_timeout"}, 32'(chan_start), 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while ((sb.size() > 0 || pending) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_sb_drain"}, sb.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts_seen;

    // Idle hold: nothing written for 1000 cycles, stray next ignored.
    reset_dut("idle");
    starts_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      next = (i == 500);
      if (chan_start) starts_seen++;
    end
    next = 1'b0;
    check_eq("idle_starts", starts_seen, 0);
    check_eq("idle_blank", 32'(disp_blank), 1);
    check_eq("idle_display", 32'(display_value), 0);
    check_eq("idle_chan", 32'(cur_chan), 0);

    // Two channels alternate.
    reset_dut("alt");
    write_chans(4'b0101, {16'h0, 16'hBEEF, 16'h0, 16'h1234}, 4'b0000);
    predict(4, 0);
    drain("alt", 200);

    // Single channel repeats on itself; capture on shown channel; async reset.
    reset_dut("solo");
    write_chans(4'b1000, {16'h00FF, 48'h0}, 4'b0000);
    predict(4, 0);
    drain("solo", 200);
    write_chans(4'b1000, {16'h0ABC, 48'h0}, 4'b0000);
    check_eq("solo_live_update", 32'(display_value), 32'h0ABC);
    check_eq("solo_chan", 32'(cur_chan), 3);
    reset_dut("midshow");
    repeat (20) @(negedge clk);
    check_eq("post_rst_blank", 32'(disp_blank), 1);
    check_eq("post_rst_display", 32'(display_value), 0);
    check_eq("post_rst_chan", 32'(cur_chan), 0);

    // Pause freezes dwell; next advances regardless of pause.
    reset_dut("pause");
    write_chans(4'b0010, {32'h0, 16'hA5A5, 16'h0}, 4'b0000);
    predict(1, 0);
    wait_start("pause", 20);
    predict(1, 54);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("pause_frozen", 32'(chan_start), 0);
    next = 1'b1;
    @(negedge clk);
    next  = 1'b0;
    pause = 1'b0;
    check_eq("next_advance", 32'(chan_start), 1);
    drain("pause", 50);

`ifdef DISP_ALARM_BLINK_EN
    // Alarm blink only while the alarmed channel is shown.
    reset_dut("blink");
    write_chans(4'b0011, {32'h0, 16'h1111, 16'h2222}, 4'b0010);
    predict(2, 0);
    wait_start("blink1", 20);
    for (int k = 0; k < c_DWELL; k++) begin
      @(negedge clk);
      check_eq("blink_alarm_chan", 32'(disp_blank), (k / c_BLINK) % 2);
    end
    wait_start("blink0", 20);
    for (int k = 0; k < c_DWELL; k++) begin
      @(negedge clk);
      check_eq("blink_quiet_chan", 32'(disp_blank), 0);
    end
    drain("blink", 50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 200000000, clk cycles each channel is shown (2 s at 100 MHz); legal range 2..2^28-1.
REQ-002 Parameter BLINK_CYCLES, default 25000000, half-period in clk cycles of the alarm blink.
REQ-003 clk  input  1  100 MHz system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
REQ-005 src_valid  input  4  per-channel one-cycle capture strobe.
REQ-006 src_data  input  64  channel i value on bits [16i+15:16i].
REQ-007 src_alarm  input  4  per-channel level alarm flag, sampled with src_valid.
REQ-008 pause  input  1  level; freezes dwell counting.
REQ-009 next  input  1  one-cycle manual-advance pulse.
REQ-010 display_value  output  16  value driven to the 4-digit hex display driver.
REQ-011 cur_chan  output  2  index of the channel shown.
REQ-012 disp_blank  output  1  request to blank all digits.
REQ-013 chan_start  output  1  one-cycle pulse when a new channel display period begins.

Function
REQ-014 Each channel has a 16-bit holding register, an alarm bit and a populated bit; src_valid[i] loads data and alarm and sets populated, every cycle, in every state.
REQ-015 States: IDLE (no channel populated), SHOW (dwell counter running), ADVANCE (one-cycle search).
REQ-016 IDLE: display_value=0, cur_chan=0, disp_blank=1; the first cycle any populated bit is 1 moves to ADVANCE.
REQ-017 ADVANCE: select the first populated channel in round-robin order starting at cur_chan+1 mod 4, wrapping back to cur_chan itself if it is the only populated one; load dwell counter with 0; pulse chan_start; enter SHOW.
REQ-018 SHOW: counter increments per cycle unless pause=1; at count DWELL_CYCLES-1 go to ADVANCE.
REQ-019 next=1 in SHOW goes to ADVANCE the following cycle regardless of pause or counter value.
REQ-020 display_value is combinationally the holding register of cur_chan when registered; a capture on cur_chan appears on display_value the cycle after src_valid.
REQ-021 Same-cycle src_valid on any channel and a SHOW-to-ADVANCE transition: capture completes first; ADVANCE sees updated populated bits.
REQ-022 next during ADVANCE or IDLE is ignored.
REQ-023 disp_blank=0 in SHOW and ADVANCE unless REQ-028 applies.
REQ-024 Dwell counter is 28 bits; no wrap occurs within legal DWELL_CYCLES.

Reset
REQ-025 While rst_n=0: state IDLE, all holding registers, alarm and populated bits 0, counters 0, display_value=0, cur_chan=0, disp_blank=1, chan_start=0.
REQ-026 Reset asserted mid-SHOW or mid-ADVANCE discards all captured data; operation restarts from IDLE.

Configuration
REQ-027 Macro DISP_ALARM_BLINK_EN selects the alarm-blink feature.
REQ-028 Defined: a BLINK_CYCLES counter toggles a blink phase; in SHOW, if the alarm bit of cur_chan is 1, disp_blank follows blink phase (starting at 0 on entry to SHOW).
REQ-029 Undefined: no blink counter exists; alarm bits are not stored; src_alarm is ignored.

Structure
REQ-030 Shared package holds the state enumeration, NUM_CHAN=4 and CHAN_W=2.
REQ-031 One sub-module, disp_rr_pick: combinational 4-bit round-robin first-set search from a start index.

Verification
REQ-032 Reset, no src_valid for 1000 cycles -> IDLE held, disp_blank=1, display_value=0.
REQ-033 DWELL_CYCLES=10; write ch0=0x1234, ch2=0xBEEF -> display alternates 0x1234/0xBEEF, each for 10 SHOW cycles plus one ADVANCE, chan_start each switch.
REQ-034 Only ch3 populated with 0x00FF -> cur_chan stays 3, chan_start every 11 cycles.
REQ-035 pause=1 for 50 cycles mid-dwell then next pulse -> counter frozen, advance on next cycle after next.
REQ-036 With DISP_ALARM_BLINK_EN, BLINK_CYCLES=4, ch1 alarm=1 -> disp_blank toggles every 4 cycles only while cur_chan=1.
REQ-037 rst_n pulsed low mid-SHOW -> all outputs at reset values asynchronously, IDLE after release.
